// File: rtl/hx8352_pkg.sv
// Shared constants and types for the HX8352 panel-side bus responder.
package hx8352_pkg;

   localparam logic        LCD_CMD        = 1'b0;
   localparam logic        LCD_DATA       = 1'b1;
   localparam logic [7:0]  GRAM_INDEX_DEF = 8'h22;
   localparam logic [15:0] ID_VALUE_DEF   = 16'h0052;

   localparam int EVT_W = 25;

   typedef struct packed {
      logic        is_data;
      logic [7:0]  index;
      logic [15:0] data;
   } evt_t;

   typedef enum logic {
      RD_IDLE  = 1'b0,
      RD_DRIVE = 1'b1
   } rd_state_e;

endpackage

// File: rtl/hx8352_bus_responder_if.sv
// Pin-side 8080 bus plus the captured-event stream of the HX8352 responder.
interface hx8352_bus_responder_if;

   logic        lcd_cs;
   logic        lcd_rs;
   logic        lcd_wr;
   logic        lcd_rd;
   logic [15:0] lcd_data_in;
   logic [15:0] lcd_data_out;
   logic        lcd_data_oe;

   // Event stream: an event transfers on every clock edge where evt_valid and
   // evt_ready are both high; evt_* are stable while evt_valid waits for ready.
   logic        evt_valid;
   logic        evt_ready;
   logic        evt_is_data;
   logic [7:0]  evt_index;
   logic [15:0] evt_data;

   modport master (
      output lcd_cs, lcd_rs, lcd_wr, lcd_rd, lcd_data_in, evt_ready,
      input  lcd_data_out, lcd_data_oe, evt_valid, evt_is_data, evt_index, evt_data
   );

   modport slave (
      input  lcd_cs, lcd_rs, lcd_wr, lcd_rd, lcd_data_in, evt_ready,
      output lcd_data_out, lcd_data_oe, evt_valid, evt_is_data, evt_index, evt_data
   );

endinterface

// File: rtl/hx8352_evt_fifo.sv
// First-word-fall-through FIFO; a push into a full FIFO succeeds only when a pop frees a slot.
module hx8352_evt_fifo #(
   parameter int W     = 25,
   parameter int DEPTH = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         push,
   input  logic [W-1:0] din,
   input  logic         pop,
   output logic [W-1:0] dout,
   output logic         full,
   output logic         empty
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [AW:0]   count;
   logic          do_push;
   logic          do_pop;

   assign empty   = (count == '0);
   assign full    = (count == (AW+1)'(DEPTH));
   assign do_pop  = pop & ~empty;
   assign do_push = push & (~full | do_pop);
   assign dout    = mem[rd_ptr];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else begin
         if (do_push) begin
            mem[wr_ptr] <= din;
            wr_ptr      <= wr_ptr + AW'(1);
         end
         if (do_pop) rd_ptr <= rd_ptr + AW'(1);
         case ({do_push, do_pop})
            2'b10:   count <= count + (AW+1)'(1);
            2'b01:   count <= count - (AW+1)'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/hx8352_bus_responder.sv
// Panel-side HX8352 8080 bus responder: index/register file, read driver,
// GRAM write counter and an event stream of captured writes.
module hx8352_bus_responder
   import hx8352_pkg::*;
#(
   parameter int          REG_DEPTH  = 128,
   parameter logic [7:0]  GRAM_INDEX = GRAM_INDEX_DEF,
   parameter logic [15:0] ID_VALUE   = ID_VALUE_DEF,
   parameter int          FIFO_DEPTH = 4
) (
   input  logic                   clk,
   input  logic                   rst,
   hx8352_bus_responder_if.slave  bus,
   input  logic                   clear_flags,
   output logic [31:0]            gram_count,
   output logic                   overflow,
   output logic                   proto_err,
   output rd_state_e              rd_state
);

   localparam int         AW        = (REG_DEPTH > 1) ? $clog2(REG_DEPTH) : 1;
   localparam logic [8:0] DEPTH_LIM = 9'(REG_DEPTH);

   logic [1:0]  cs_q, rs_q, wr_q, rd_q;
   logic [15:0] data_q1, data_q2;
   logic        wr_d, rd_d;
   logic        cs_s, rs_s, wr_s, rd_s;
   logic [15:0] data_s;

   // Strobe synchronizers reset low and cs resets high, so neither a phantom
   // protocol error nor an arming can occur before real pin samples arrive.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cs_q    <= 2'b11;
         rs_q    <= 2'b00;
         wr_q    <= 2'b00;
         rd_q    <= 2'b00;
         data_q1 <= '0;
         data_q2 <= '0;
         wr_d    <= 1'b0;
         rd_d    <= 1'b0;
      end else begin
         cs_q    <= {cs_q[0], bus.lcd_cs};
         rs_q    <= {rs_q[0], bus.lcd_rs};
         wr_q    <= {wr_q[0], bus.lcd_wr};
         rd_q    <= {rd_q[0], bus.lcd_rd};
         data_q1 <= bus.lcd_data_in;
         data_q2 <= data_q1;
         wr_d    <= wr_q[1];
         rd_d    <= rd_q[1];
      end
   end

   assign cs_s   = cs_q[1];
   assign rs_s   = rs_q[1];
   assign wr_s   = wr_q[1];
   assign rd_s   = rd_q[1];
   assign data_s = data_q2;

   logic armed;
   logic proto_now;
   logic wr_rise, rd_fall, rd_rise;

   assign proto_now = ~cs_s & ~wr_s & ~rd_s;
   assign wr_rise   = armed & ~proto_now & ~cs_s & wr_s & ~wr_d;
   assign rd_fall   = armed & ~proto_now & ~cs_s & ~rd_s & rd_d;
   assign rd_rise   = rd_s & ~rd_d;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)                armed <= 1'b0;
      else if (proto_now)     armed <= 1'b0;
      else if (wr_s && rd_s)  armed <= 1'b1;
   end

   logic [7:0]  index;
   logic [15:0] regs [REG_DEPTH];
   logic        in_range;

   assign in_range = ({1'b0, index} < DEPTH_LIM);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         index      <= '0;
         gram_count <= '0;
         for (int i = 0; i < REG_DEPTH; i++) regs[i] <= '0;
      end else if (wr_rise) begin
         if (rs_s == LCD_CMD)
            index <= data_s[7:0];
         else if (index == GRAM_INDEX)
            gram_count <= gram_count + 32'd1;
         else if (index != 8'h00 && in_range)
            regs[index[AW-1:0]] <= data_s;
      end
   end

   evt_t evt_in, evt_out;
   logic fifo_full, fifo_empty;

   assign evt_in = {rs_s, (rs_s == LCD_CMD) ? data_s[7:0] : index, data_s};

   hx8352_evt_fifo #(.W(EVT_W), .DEPTH(FIFO_DEPTH)) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (wr_rise),
      .din   (evt_in),
      .pop   (bus.evt_ready),
      .dout  (evt_out),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   assign bus.evt_valid   = ~fifo_empty;
   assign bus.evt_is_data = evt_out.is_data;
   assign bus.evt_index   = evt_out.index;
   assign bus.evt_data    = evt_out.data;

   logic ov_set;
   assign ov_set = wr_rise & fifo_full & ~bus.evt_ready;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         overflow  <= 1'b0;
         proto_err <= 1'b0;
      end else begin
         overflow  <= ov_set | (overflow & ~clear_flags);
         proto_err <= proto_now | (proto_err & ~clear_flags);
      end
   end

   rd_state_e   state, state_n;
   logic        load_out;
   logic [15:0] read_val;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= RD_IDLE;
      else     state <= state_n;
   end

   always_comb begin
      state_n  = state;
      load_out = 1'b0;
      case (state)
         RD_IDLE: begin
            if (rd_fall) begin
               state_n  = RD_DRIVE;
               load_out = 1'b1;
            end
         end
         RD_DRIVE: begin
            if (rd_rise || cs_s || proto_now) state_n = RD_IDLE;
         end
         default: state_n = RD_IDLE;
      endcase
   end

   always_comb begin
      read_val = 16'h0000;
      if (rs_s == LCD_DATA) begin
         if (index == 8'h00)            read_val = ID_VALUE;
         else if (index == GRAM_INDEX)  read_val = 16'h0000;
         else if (in_range)             read_val = regs[index[AW-1:0]];
      end else begin
         read_val = {8'h00, index};
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)           bus.lcd_data_out <= '0;
      else if (load_out) bus.lcd_data_out <= read_val;
   end

   assign bus.lcd_data_oe = (state == RD_DRIVE);
   assign rd_state        = state;

endmodule

// File: tb/tb_hx8352_bus_responder.sv
// Directed bench for hx8352_bus_responder: host bus driver tasks, event
// scoreboard with an independent pop monitor, and direct status checks.
module tb_hx8352_bus_responder;
   import hx8352_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic        clear_flags;
   logic [31:0] gram_count;
   logic        overflow;
   logic        proto_err;
   rd_state_e   rd_state;

   hx8352_bus_responder_if bus ();

   hx8352_bus_responder dut (
      .clk         (clk),
      .rst         (rst),
      .bus         (bus),
      .clear_flags (clear_flags),
      .gram_count  (gram_count),
      .overflow    (overflow),
      .proto_err   (proto_err),
      .rd_state    (rd_state)
   );

   always #5 clk = ~clk;

   logic [24:0] exp_q[$];
   int n_vec = 0;
   int n_bad = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic idle_cycles(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic bus_write(input logic rs, input logic [15:0] d,
                            input logic [24:0] ev, input bit expect_evt);
      @(negedge clk);
      bus.lcd_cs      = 1'b0;
      bus.lcd_rs      = rs;
      bus.lcd_data_in = d;
      bus.lcd_wr      = 1'b0;
      if (expect_evt) exp_q.push_back(ev);
      idle_cycles(4);
      bus.lcd_wr = 1'b1;
      idle_cycles(4);
      bus.lcd_cs = 1'b1;
   endtask

   task automatic bus_read(input logic rs, input logic [15:0] exp, input string name);
      @(negedge clk);
      bus.lcd_cs = 1'b0;
      bus.lcd_rs = rs;
      bus.lcd_rd = 1'b0;
      idle_cycles(5);
      check({name, "_oe"}, 32'(bus.lcd_data_oe), 32'd1);
      check({name, "_data"}, 32'(bus.lcd_data_out), 32'(exp));
      bus.lcd_rd = 1'b1;
      idle_cycles(4);
      check({name, "_oe_off"}, 32'(bus.lcd_data_oe), 32'd0);
      bus.lcd_cs = 1'b1;
   endtask

   task automatic drain(input string name);
      int k;
      k = 0;
      while (exp_q.size() != 0 && k < 50) begin
         @(negedge clk);
         k++;
      end
      check({name, "_drained"}, 32'(exp_q.size()), 32'd0);
   endtask

   task automatic pulse_clear();
      @(negedge clk);
      clear_flags = 1'b1;
      @(negedge clk);
      clear_flags = 1'b0;
      idle_cycles(1);
   endtask

   // Pop monitor: the handshake values are stable from just after the
   // falling edge until the rising edge that performs the transfer.
   initial begin
      logic [24:0] got, e;
      forever begin
         @(negedge clk);
         #1;
         if (!rst && bus.evt_valid && bus.evt_ready) begin
            got = {bus.evt_is_data, bus.evt_index, bus.evt_data};
            n_vec++;
            if (exp_q.size() == 0) begin
               n_bad++;
               $display("FAIL evt_pop: got %h expected none", got);
            end else begin
               e = exp_q.pop_front();
               if (got !== e) begin
                  n_bad++;
                  $display("FAIL evt_pop: got %h expected %h", got, e);
               end
            end
         end
      end
   end

   initial begin
      #200us;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   logic [15:0] gram_vals [5] = '{16'h1111, 16'h2222, 16'h3333, 16'h4444, 16'h5555};

   initial begin
      rst             = 1'b1;
      clear_flags     = 1'b0;
      bus.lcd_cs      = 1'b1;
      bus.lcd_rs      = 1'b0;
      bus.lcd_wr      = 1'b1;
      bus.lcd_rd      = 1'b1;
      bus.lcd_data_in = 16'h0000;
      bus.evt_ready   = 1'b1;
      idle_cycles(3);

      check("rst_oe", 32'(bus.lcd_data_oe), 32'd0);
      check("rst_data_out", 32'(bus.lcd_data_out), 32'd0);
      check("rst_evt_valid", 32'(bus.evt_valid), 32'd0);
      check("rst_evt_fields", 32'({bus.evt_is_data, bus.evt_index, bus.evt_data}), 32'd0);
      check("rst_gram_count", gram_count, 32'd0);
      check("rst_flags", 32'({overflow, proto_err}), 32'd0);
      check("rst_state", 32'(rd_state), 32'd0);

      @(negedge clk);
      rst = 1'b0;
      idle_cycles(5);

      // Index then data write, readback and status read
      bus_write(LCD_CMD,  16'h0003, {1'b0, 8'h03, 16'h0003}, 1'b1);
      bus_write(LCD_DATA, 16'hABCD, {1'b1, 8'h03, 16'hABCD}, 1'b1);
      drain("idx_data");
      bus_read(LCD_DATA, 16'hABCD, "rd_reg03");
      bus_read(LCD_CMD,  16'h0003, "rd_status");

      // Index 0 is read-only and returns the ID
      bus_write(LCD_CMD,  16'h0000, {1'b0, 8'h00, 16'h0000}, 1'b1);
      bus_write(LCD_DATA, 16'h1234, {1'b1, 8'h00, 16'h1234}, 1'b1);
      drain("id");
      bus_read(LCD_DATA, 16'h0052, "rd_id");

      // Index beyond the register file
      bus_write(LCD_CMD,  16'h0090, {1'b0, 8'h90, 16'h0090}, 1'b1);
      bus_write(LCD_DATA, 16'hBEEF, {1'b1, 8'h90, 16'hBEEF}, 1'b1);
      drain("oob");
      bus_read(LCD_DATA, 16'h0000, "rd_oob");

      // GRAM path
      bus_write(LCD_CMD, 16'h0022, {1'b0, 8'h22, 16'h0022}, 1'b1);
      for (int i = 0; i < 5; i++)
         bus_write(LCD_DATA, gram_vals[i], {1'b1, 8'h22, gram_vals[i]}, 1'b1);
      drain("gram");
      check("gram_count", gram_count, 32'd5);
      bus_read(LCD_DATA, 16'h0000, "rd_gram");

      // Overflow: six writes into a four-entry FIFO with no consumer
      @(negedge clk);
      bus.evt_ready = 1'b0;
      bus_write(LCD_CMD,  16'h0005, {1'b0, 8'h05, 16'h0005}, 1'b1);
      bus_write(LCD_DATA, 16'h1111, {1'b1, 8'h05, 16'h1111}, 1'b1);
      bus_write(LCD_DATA, 16'h2222, {1'b1, 8'h05, 16'h2222}, 1'b1);
      bus_write(LCD_DATA, 16'h3333, {1'b1, 8'h05, 16'h3333}, 1'b1);
      bus_write(LCD_DATA, 16'h4444, {1'b1, 8'h05, 16'h4444}, 1'b0);
      bus_write(LCD_DATA, 16'h5555, {1'b1, 8'h05, 16'h5555}, 1'b0);
      check("ovf_flag", 32'(overflow), 32'd1);
      check("ovf_head", 32'({bus.evt_valid, bus.evt_is_data, bus.evt_index, bus.evt_data}),
            32'({1'b1, 1'b0, 8'h05, 16'h0005}));
      bus_read(LCD_DATA, 16'h5555, "rd_ovf_reg");
      pulse_clear();
      check("ovf_cleared", 32'(overflow), 32'd0);
      @(negedge clk);
      bus.evt_ready = 1'b1;
      drain("ovf");

      // Protocol error: wr and rd low together under cs
      @(negedge clk);
      bus.lcd_cs = 1'b0;
      bus.lcd_rs = 1'b1;
      bus.lcd_wr = 1'b0;
      bus.lcd_rd = 1'b0;
      idle_cycles(6);
      check("perr_flag", 32'(proto_err), 32'd1);
      check("perr_oe", 32'(bus.lcd_data_oe), 32'd0);
      check("perr_no_evt", 32'(bus.evt_valid), 32'd0);
      bus.lcd_wr = 1'b1;
      bus.lcd_rd = 1'b1;
      idle_cycles(6);
      check("perr_release_no_evt", 32'(bus.evt_valid), 32'd0);
      check("perr_release_oe", 32'(bus.lcd_data_oe), 32'd0);
      bus.lcd_cs = 1'b1;
      bus_write(LCD_CMD,  16'h0007, {1'b0, 8'h07, 16'h0007}, 1'b1);
      bus_write(LCD_DATA, 16'h7777, {1'b1, 8'h07, 16'h7777}, 1'b1);
      drain("perr_recover");
      check("perr_sticky", 32'(proto_err), 32'd1);
      pulse_clear();
      check("perr_cleared", 32'(proto_err), 32'd0);

      // Reset in the middle of a read
      @(negedge clk);
      bus.lcd_cs = 1'b0;
      bus.lcd_rs = 1'b1;
      bus.lcd_rd = 1'b0;
      idle_cycles(5);
      check("mid_rd_oe", 32'(bus.lcd_data_oe), 32'd1);
      check("mid_rd_data", 32'(bus.lcd_data_out), 32'h7777);
      rst = 1'b1;
      #1;
      check("mid_rst_oe_async", 32'(bus.lcd_data_oe), 32'd0);
      idle_cycles(2);
      rst = 1'b0;
      idle_cycles(8);
      check("post_rst_oe", 32'(bus.lcd_data_oe), 32'd0);
      check("post_rst_data", 32'(bus.lcd_data_out), 32'd0);
      bus.lcd_rd = 1'b1;
      idle_cycles(5);
      check("post_rst_rd_high_oe", 32'(bus.lcd_data_oe), 32'd0);
      bus.lcd_rd = 1'b0;
      idle_cycles(5);
      check("fresh_rd_oe", 32'(bus.lcd_data_oe), 32'd1);
      check("fresh_rd_data", 32'(bus.lcd_data_out), 32'h0052);
      bus.lcd_rd = 1'b1;
      idle_cycles(4);
      bus.lcd_cs = 1'b1;
      check("fresh_rd_oe_off", 32'(bus.lcd_data_oe), 32'd0);
      check("final_queue_empty", 32'(exp_q.size()), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
